fetch_stage: RTL

- Instruction-fetch stage that sits directly upstream of the branch unit and consumes its redirect outputs (PcSel, BrPC).
- Owns the PC register and issues single-outstanding requests to instruction memory, which has variable latency.
- Fills the IF/ID pipeline register and honours hazard-unit stalls.
- Handles branch/jump redirects: squashes in-flight fetches and flushes IF/ID.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/fetch_hold_buf.sv | 46 ++++
 rtl/fetch_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int unsigned FETCH_PC_W   = 9;
    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_FLUSH = 3'd3,
        S_HOLD  = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic                  valid;
        logic [FETCH_PC_W-1:0] pc;
        logic [31:0]           instr;
    } if_id_t;

endpackage

`default_nettype wire

// File: rtl/fetch_hold_buf.sv
// ============================================================================
//  Module      : fetch_hold_buf
//  Description : One-entry {pc, instr} skid register for responses under stall.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_hold_buf #(
    parameter int unsigned PC_W = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    output logic [PC_W-1:0] pc_o,
    output logic [31:0]     instr_o
);

    logic            valid_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : PC register, single-outstanding imem fetch FSM and IF/ID reg.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
    import riscv_pkg::*;
#(
    // Must equal FETCH_PC_W: the IF/ID struct is sized from the package.
    parameter int unsigned PC_W      = FETCH_PC_W,
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            pc_sel,
    input  logic [31:0]     br_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_instr
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;

    logic            hb_load, hb_clear, hb_valid;
    logic [PC_W-1:0] hb_pc;
    logic [31:0]     hb_instr;

    logic            deliver;
    logic [PC_W-1:0] deliver_pc;
    logic [31:0]     deliver_instr;

    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_inc;
    logic            br_pc_unused;

    assign target       = {br_pc[PC_W-1:2], 2'b00};
    assign pc_inc       = pc_q + PC_W'(4);
    assign br_pc_unused = ^{br_pc[31:PC_W], br_pc[1:0]};

    fetch_hold_buf #(
        .PC_W (PC_W)
    ) u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (hb_load),
        .clear_i (hb_clear),
        .pc_i    (pc_q),
        .instr_i (imem_rdata),
        .valid_o (hb_valid),
        .pc_o    (hb_pc),
        .instr_o (hb_instr)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        imem_req      = 1'b0;
        hb_load       = 1'b0;
        hb_clear      = 1'b0;
        deliver       = 1'b0;
        deliver_pc    = pc_q;
        deliver_instr = imem_rdata;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                imem_req = 1'b1;
                // The request still goes out; a redirect makes its reply stale.
                if (pc_sel) begin
                    pc_d    = target;
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (pc_sel) begin
                        pc_d    = target;
                        state_d = S_REQ;
                    end else if (!stall) begin
                        deliver = 1'b1;
                        pc_d    = pc_inc;
                        state_d = S_REQ;
                    end else begin
                        hb_load = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (pc_sel) begin
                    pc_d    = target;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (pc_sel) pc_d = target;
                if (imem_rvalid) state_d = S_REQ;
            end
            S_HOLD: begin
                if (pc_sel) begin
                    hb_clear = 1'b1;
                    pc_d     = target;
                    state_d  = S_REQ;
                end else if (!stall && hb_valid) begin
                    hb_clear      = 1'b1;
                    deliver       = 1'b1;
                    deliver_pc    = hb_pc;
                    deliver_instr = hb_instr;
                    pc_d          = pc_inc;
                    state_d       = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if_id_d = if_id_q;
        if (pc_sel) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end else if (stall) begin
            if_id_d = if_id_q;
        end else if (deliver) begin
            if_id_d.valid = 1'b1;
            if_id_d.pc    = deliver_pc;
            if_id_d.instr = deliver_instr;
        end else begin
            if_id_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            if_id_q.valid <= 1'b0;
            if_id_q.pc    <= '0;
            if_id_q.instr <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    assign imem_addr = pc_q;
    assign id_valid  = if_id_q.valid;
    assign id_pc     = if_id_q.pc;
    assign id_instr  = if_id_q.instr;

endmodule

`default_nettype wire
